// File: rtl/rega_scheduler.sv
// rega_scheduler: central sequencer for the irrigation controller.
// Arbitrates the shared water line between aspersion, drip and the
// fertilization sequence (fill -> mix -> clean). Paced by a one-cycle Tick.
//
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   Tick            one-Clk timebase pulse
//   Us, Bs, Vs, T1  soil dry, tank above low mark, tank full, high temperature
//   Adub            fertilization request (level; its rising edge is latched)
//   A, G, Ve        aspersion, drip and tank inlet valves
//   Mist, Limp      mixer and cleaning pump
//   Busy, Err       active-sequence flag, sticky fault flag
//   State, Tmr      current state code, remaining ticks in timed states
module rega_scheduler #(
   parameter int unsigned T_ASP   = 10,
   parameter int unsigned T_GOT   = 15,
   parameter int unsigned T_MIX   = 5,
   parameter int unsigned T_LIMP  = 8,
   parameter int unsigned T_FILL  = 20,
   parameter int unsigned TIMER_W = 5
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Tick,
   input  logic               Us,
   input  logic               Bs,
   input  logic               Vs,
   input  logic               T1,
   input  logic               Adub,
   output logic               A,
   output logic               G,
   output logic               Ve,
   output logic               Mist,
   output logic               Limp,
   output logic               Busy,
   output logic               Err,
   output logic [2:0]         State,
   output logic [TIMER_W-1:0] Tmr
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAsp   = 3'd1,
      StGot   = 3'd2,
      StFill  = 3'd3,
      StMix   = 3'd4,
      StLimp  = 3'd5,
      StFault = 3'd6
   } state_e;

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   tmr_q, tmr_d;
   logic                 pend_q, pend_d;
   logic                 adub_q;
   logic                 expire;
   logic                 sensor_bad;

   // Expiry is the Tick that would take the counter from 1 to 0.
   assign expire     = Tick && (tmr_q == TIMER_W'(1));
   assign sensor_bad = Vs && !Bs;

   // Next-state logic; the sensor fault check precedes every other decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (sensor_bad)      state_d = StFault;
            else if (pend_q)     state_d = Vs ? StMix : StFill;
            else if (Us && Bs)   state_d = (Vs && !T1) ? StAsp : StGot;
         end
         StAsp, StGot: begin
            // Abort beats preempt beats expiry; all three land in IDLE.
            if (sensor_bad)      state_d = StFault;
            else if (!Bs)        state_d = StIdle;
            else if (pend_q)     state_d = StIdle;
            else if (expire)     state_d = StIdle;
         end
         StFill: begin
            if (sensor_bad)      state_d = StFault;
            else if (Vs)         state_d = StMix;
            else if (expire)     state_d = StFault;
         end
         StMix: begin
            if (sensor_bad)      state_d = StFault;
            else if (expire)     state_d = StLimp;
         end
         StLimp: begin
            if (sensor_bad)      state_d = StFault;
            else if (expire)     state_d = StIdle;
         end
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
   end

   // Timer loads on the entry edge, so a Tick coincident with entry is not counted.
   always_comb begin
      tmr_d = tmr_q;
      if (state_d != state_q) begin
         case (state_d)
            StAsp:   tmr_d = TIMER_W'(T_ASP);
            StGot:   tmr_d = TIMER_W'(T_GOT);
            StFill:  tmr_d = TIMER_W'(T_FILL);
            StMix:   tmr_d = TIMER_W'(T_MIX);
            StLimp:  tmr_d = TIMER_W'(T_LIMP);
            default: tmr_d = '0;
         endcase
      end else if (Tick && (tmr_q != '0)) begin
         tmr_d = tmr_q - TIMER_W'(1);
      end
   end

   // A fresh request edge wins over the clear on MIX entry so it is not lost.
   always_comb begin
      pend_d = pend_q;
      if ((state_d == StMix) && (state_q != StMix)) pend_d = 1'b0;
      if (Adub && !adub_q)                          pend_d = 1'b1;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= StIdle;
         tmr_q   <= '0;
         pend_q  <= 1'b0;
         adub_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pend_q  <= pend_d;
         adub_q  <= Adub;
      end
   end

   // Actuator outputs are flops decoded from the next state, so they track State exactly.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         A    <= 1'b0;
         G    <= 1'b0;
         Ve   <= 1'b0;
         Mist <= 1'b0;
         Limp <= 1'b0;
         Busy <= 1'b0;
         Err  <= 1'b0;
      end else begin
         A    <= (state_d == StAsp);
         G    <= (state_d == StGot);
         Ve   <= (state_d == StFill);
         Mist <= (state_d == StMix);
         Limp <= (state_d == StLimp);
         Busy <= (state_d != StIdle) && (state_d != StFault);
         Err  <= (state_d == StFault);
      end
   end

   assign State = state_q;
   assign Tmr   = tmr_q;

endmodule

// File: tb/tb_rega_scheduler.sv
// Directed bench for rega_scheduler with hand-computed expectations.
module tb_rega_scheduler;

   logic       Clk, Rst, Tick, Us, Bs, Vs, T1, Adub;
   logic       A, G, Ve, Mist, Limp, Busy, Err;
   logic [2:0] State;
   logic [4:0] Tmr;

   int total = 0;
   int bad   = 0;
   int multi_valve = 0;

   rega_scheduler dut (
      .Clk(Clk), .Rst(Rst), .Tick(Tick), .Us(Us), .Bs(Bs), .Vs(Vs), .T1(T1), .Adub(Adub),
      .A(A), .G(G), .Ve(Ve), .Mist(Mist), .Limp(Limp), .Busy(Busy), .Err(Err),
      .State(State), .Tmr(Tmr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Valve exclusivity watch, sampled mid-cycle.
   always @(negedge Clk) begin
      if ((int'(A) + int'(G) + int'(Ve) + int'(Mist) + int'(Limp)) > 1) multi_valve++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One Clk with Tick driven to tk; returns 1 time unit after the edge.
   task automatic step(input logic tk);
      Tick = tk;
      @(posedge Clk);
      #1;
      Tick = 1'b0;
   endtask

   // One Tick followed by three quiet Clks (Tick every 4 Clk).
   task automatic tick4();
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      step(1'b0);
      step(1'b0);
      Rst = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; Tick = 0; Us = 0; Bs = 0; Vs = 0; T1 = 0; Adub = 0;
      step(1'b0);
      step(1'b0);
      // Reset state
      check("rst_state", State, 0);
      check("rst_tmr", Tmr, 0);
      check("rst_valves", {A, G, Ve, Mist, Limp}, 0);
      check("rst_busy", Busy, 0);
      check("rst_err", Err, 0);
      Rst = 1'b0;

      // Aspersion
      Us = 1; Bs = 1; Vs = 1; T1 = 0;
      step(1'b0);
      check("asp_state", State, 1);
      check("asp_a", A, 1);
      check("asp_tmr", Tmr, 10);
      check("asp_busy", Busy, 1);
      for (int i = 0; i < 9; i++) tick4();
      check("asp_tmr_last", Tmr, 1);
      check("asp_still", State, 1);
      step(1'b1);
      check("asp_end_state", State, 0);
      check("asp_end_a", A, 0);
      check("asp_end_tmr", Tmr, 0);

      // Drip by temperature, then dry-run abort
      T1 = 1; Vs = 0;
      step(1'b0);
      check("got_state", State, 2);
      check("got_g", G, 1);
      check("got_tmr", Tmr, 15);
      for (int i = 0; i < 3; i++) tick4();
      check("got_tmr3", Tmr, 12);
      Bs = 0;
      step(1'b0);
      check("abort_state", State, 0);
      check("abort_g", G, 0);
      check("abort_tmr", Tmr, 0);

      // Fertilization preempts drip
      Bs = 1;
      step(1'b0);
      check("got2_state", State, 2);
      tick4();
      Adub = 1;
      step(1'b0);
      check("pend_latch_got", State, 2);
      Adub = 0;
      step(1'b0);
      check("preempt_state", State, 0);
      check("preempt_valves", {A, G, Ve, Mist, Limp}, 0);
      step(1'b0);
      check("fill_state", State, 3);
      check("fill_ve", Ve, 1);
      check("fill_tmr", Tmr, 20);
      tick4();
      tick4();
      check("fill_tmr2", Tmr, 18);
      Vs = 1; T1 = 0;
      step(1'b0);
      check("mix_state", State, 4);
      check("mix_mist", Mist, 1);
      check("mix_tmr", Tmr, 5);
      for (int i = 0; i < 4; i++) begin
         tick4();
         check("mix_no_irr", A | G, 0);
      end
      check("mix_tmr_last", Tmr, 1);
      step(1'b1);
      check("limp_state", State, 5);
      check("limp_limp", Limp, 1);
      check("limp_tmr", Tmr, 8);
      for (int i = 0; i < 7; i++) begin
         tick4();
         check("limp_no_irr", A | G, 0);
      end
      check("limp_still", State, 5);
      step(1'b1);
      check("limp_end_state", State, 0);
      check("limp_end_tmr", Tmr, 0);
      step(1'b0);
      check("redispatch_asp", State, 1);

      // Fill watchdog
      Vs = 0; Adub = 1;
      step(1'b0);
      Adub = 0;
      step(1'b0);
      check("wd_preempt", State, 0);
      step(1'b0);
      check("wd_fill", State, 3);
      for (int i = 0; i < 19; i++) tick4();
      check("wd_tmr_last", Tmr, 1);
      check("wd_still", State, 3);
      step(1'b1);
      check("wd_fault_state", State, 6);
      check("wd_fault_err", Err, 1);
      check("wd_fault_valves", {A, G, Ve, Mist, Limp}, 0);
      check("wd_fault_busy", Busy, 0);
      check("wd_fault_tmr", Tmr, 0);
      Vs = 1;
      for (int i = 0; i < 3; i++) tick4();
      check("fault_sticky", State, 6);
      check("fault_err_sticky", Err, 1);

      // Sensor fault beats abort and preempt
      do_reset();
      Us = 1; Bs = 1; Vs = 1; T1 = 0;
      step(1'b0);
      check("sf_asp", State, 1);
      Adub = 1;
      step(1'b0);
      Adub = 0; Bs = 0;
      step(1'b0);
      check("sf_fault", State, 6);
      check("sf_err", Err, 1);

      // Async reset mid-LIMP
      do_reset();
      Us = 0; Bs = 1; Vs = 1; T1 = 0; Adub = 1;
      step(1'b0);
      Adub = 0;
      step(1'b0);
      check("ar_mix", State, 4);
      for (int i = 0; i < 5; i++) tick4();
      check("ar_limp", State, 5);
      Adub = 1;
      step(1'b0);
      Adub = 0;
      step(1'b0);
      check("ar_limp_hold", State, 5);
      check("ar_limp_on", Limp, 1);
      #2;
      Rst = 1;
      #1;
      check("ar_limp_off", Limp, 0);
      check("ar_busy_off", Busy, 0);
      check("ar_tmr_off", Tmr, 0);
      check("ar_state_off", State, 0);
      step(1'b0);
      Rst = 0;
      step(1'b0);
      step(1'b0);
      check("ar_pend_clear", State, 0);

      check("valve_exclusive", multi_valve, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rega_scheduler.md
# rega_scheduler

Central sequencer for the irrigation controller: owns the shared water line and decides, cycle by cycle, whether it is used for aspersion irrigation, drip irrigation, or the fertilization/cleaning sequence (fill, mix, clean). It sits between the sensor inputs and the valve/actuator outputs, and is paced by a one-cycle tick from the clock divider. It guarantees that irrigation never runs during fertilization or cleaning, and that no valve opens on an empty tank.

## Interface
- T_ASP, 10: aspersion duration in ticks (1..2^TIMER_W-1)
- T_GOT, 15: drip duration in ticks
- T_MIX, 5: mixer duration in ticks
- T_LIMP, 8: cleaning duration in ticks
- T_FILL, 20: fill watchdog in ticks
- TIMER_W, 5: width of remaining-time counter

- Clk  in  1  system clock; the only clock
- Rst  in  1  reset, asynchronous, active-high
- Tick  in  1  one-Clk-wide timebase pulse, synchronous to Clk
- Us  in  1  soil dry (1 = irrigation wanted)
- Bs  in  1  tank above low mark
- Vs  in  1  tank at high mark
- T1  in  1  high temperature (1 = aspersion forbidden)
- Adub  in  1  fertilization request, level, synchronous
- A  out  1  aspersion valve
- G  out  1  drip valve
- Ve  out  1  tank inlet valve
- Mist  out  1  mixer
- Limp  out  1  cleaning pump
- Busy  out  1  any state other than IDLE or FAULT
- Err  out  1  sticky fault flag
- State  out  3  current state code
- Tmr  out  TIMER_W  remaining ticks in the timed state; 0 otherwise

## Operation
- States and codes: IDLE=0, ASP=1, GOT=2, FILL=3, MIX=4, LIMP=5, FAULT=6. Code 7 is illegal and returns to IDLE on the next Clk.
- Outputs are Moore and registered: A=ASP, G=GOT, Ve=FILL, Mist=MIX, Limp=LIMP, Err=FAULT.
- Pend latch: set on the rising edge of Adub (previous-cycle register) in any state. Cleared on entry to MIX, and by Rst.
- The fault check has the highest priority in every state except FAULT. The condition Vs=1 and Bs=0 (inconsistent sensors) moves the block to FAULT on the next Clk.
- IDLE dispatch, in priority order:
  - If Pend=1: go to MIX if Vs=1, otherwise go to FILL.
  - Else if Us=1 and Bs=1: go to ASP if Vs=1 and T1=0, otherwise go to GOT.
  - Else stay in IDLE.
- ASP/GOT:
  - Abort to IDLE if Bs=0 (dry-run protection).
  - Preempt to IDLE if Pend=1; IDLE dispatches on the following cycle, giving a one-cycle all-valves-off gap.
  - Otherwise count down and go to IDLE on expiry.
  - Us falling does not stop a running cycle.
- FILL:
  - Go to MIX on the first Clk with Vs=1.
  - Go to FAULT if T_FILL ticks elapse without Vs.
  - Not preemptible.
- MIX: count down, then go to LIMP. Not preemptible. Us and T1 are ignored.
- LIMP: count down, then go to IDLE. Not preemptible; irrigation is held off until it completes.
- FAULT: all actuators are 0 and Err=1. The only exit is Rst.
- Timer:
  - Loaded with the state's parameter on the entry edge.
  - Decrements on each Tick after entry; a Tick in the same cycle as the entry edge is not counted.
  - The transition happens on the edge where a Tick would take Tmr from 1 to 0. A timed state therefore lasts exactly N Ticks.
  - Tmr reads 0 in IDLE and FAULT.
  - In FILL, Tmr shows the watchdog remaining.
- Simultaneous events:
  - Rst beats everything.
  - Fault beats abort, abort beats preempt, and preempt beats expiry.
  - In IDLE, Pend beats Us.

## Timing
- Reset (asynchronous): State=0, Tmr=0, A=G=Ve=Mist=Limp=0, Busy=0, Err=0, Pend=0, Adub edge register=0.
- Reset asserted mid-operation closes all valves immediately, without waiting for Clk.
- Dispatch latency: one Clk from the IDLE condition becoming true to the valve output being asserted.
- Valves change only on Clk edges. No two of A, G, Ve, Mist, Limp are ever 1 in the same cycle.
- Preempt ASP/GOT → IDLE → FILL/MIX costs 2 Clk. The valve gap is exactly 1 Clk.
- Tick may be adjacent on consecutive Clks; each Tick decrements by exactly 1.

## Test plan
- Aspersion: Rst; set Us=1, Bs=1, Vs=1, T1=0; Tick every 4 Clk.
  - Expect State=1 and A=1 one Clk later, with Tmr=10.
  - A drops and State=0 on the edge of the 10th Tick after entry.
- Drip by temperature and dry-run abort: set T1=1 → State=2, G=1. Drop Bs=0 after 3 Ticks → G=0 and State=0 next Clk, with Tmr=0.
- Fertilization preempts drip: in GOT, pulse Adub with Vs=0. Expect, one Clk at a time:
  - State=0 with all valves 0.
  - Then FILL with Ve=1.
  - When Vs=1: MIX for 5 Ticks, then LIMP for 8 Ticks, then IDLE.
  - Us=1 throughout must not assert A or G before LIMP ends.
- Fill watchdog: enter FILL with Vs held 0. After 20 Ticks: State=6, Err=1, all valves 0. Remains in FAULT until Rst.
- Sensor fault and priority: from ASP, set Vs=1 and Bs=0 in the same cycle as a pending Adub. Expect State=6 next Clk.
- Async reset mid-LIMP: assert Rst between Clk edges. Limp, Busy and Tmr go to 0 before the next edge, and Pend is cleared.
